// File: rtl/hazard_unit_if.sv
// Hazard interface between the pipeline (datapath + controller) and the hazard unit.
// The pipeline side is the master: it supplies register addresses and stage status,
// and receives forwarding selects, stall/flush controls and the event counters.
interface hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] Rs1_D;
  logic [REG_W-1:0] Rs2_D;
  logic [REG_W-1:0] Rd_D;
  logic             RegWrite_M;
  logic             RegWrite_W;
  logic             ResultSrc_E0;
  logic             PCSrcE;
  logic [1:0]       ForwardA_E;
  logic [1:0]       ForwardB_E;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output Rs1_D, Rs2_D, Rd_D, RegWrite_M, RegWrite_W, ResultSrc_E0, PCSrcE,
    input  ForwardA_E, ForwardB_E, StallF, StallD, FlushD, FlushE, stall_cnt, flush_cnt
  );

  modport slave (
    input  Rs1_D, Rs2_D, Rd_D, RegWrite_M, RegWrite_W, ResultSrc_E0, PCSrcE,
    output ForwardA_E, ForwardB_E, StallF, StallD, FlushD, FlushE, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage RISC-V pipeline.
// Tracks source/destination register addresses through E/M/W, produces forwarding
// selects, load-use stalls and branch flushes, and counts stall/flush events with
// saturating counters for performance debug.
module hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_if.slave hz
);

  logic [REG_W-1:0] rs1_e_q, rs1_e_d;
  logic [REG_W-1:0] rs2_e_q, rs2_e_d;
  logic [REG_W-1:0] rd_e_q,  rd_e_d;
  logic [REG_W-1:0] rd_m_q,  rd_m_d;
  logic [REG_W-1:0] rd_w_q,  rd_w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lw_raw;
  logic             lw_stall;
  logic             flush_e;

  // M has priority over W because it holds the younger result; x0 is hard-wired zero
  // and must never pick up a forwarded value.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs_e,
                                         input logic [REG_W-1:0] rd_m,
                                         input logic [REG_W-1:0] rd_w,
                                         input logic             wr_m,
                                         input logic             wr_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs_e != '0) begin
      if (wr_m && (rs_e == rd_m)) begin
        sel = 2'b10;
      end else if (wr_w && (rs_e == rd_w)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  // Increment-and-hold: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             en);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (en && (cnt != {CNT_W{1'b1}})) begin
      res = cnt + CNT_W'(1);
    end
    return res;
  endfunction

  // Hazard detection and control outputs; reset masks everything that depends on
  // stale pipeline state, while input-driven flushes still pass through.
  always_comb begin
    lw_raw   = hz.ResultSrc_E0 && (rd_e_q != '0) &&
               ((hz.Rs1_D == rd_e_q) || (hz.Rs2_D == rd_e_q));
    // A taken branch squashes the Decode instruction, so stalling it is pointless.
    lw_stall = lw_raw && !hz.PCSrcE && !reset;
    flush_e  = lw_stall || hz.PCSrcE;

    hz.ForwardA_E = reset ? 2'b00 : fwd_sel(rs1_e_q, rd_m_q, rd_w_q, hz.RegWrite_M, hz.RegWrite_W);
    hz.ForwardB_E = reset ? 2'b00 : fwd_sel(rs2_e_q, rd_m_q, rd_w_q, hz.RegWrite_M, hz.RegWrite_W);
    hz.StallF     = lw_stall;
    hz.StallD     = lw_stall;
    hz.FlushD     = hz.PCSrcE;
    hz.FlushE     = flush_e;
    hz.stall_cnt  = stall_cnt_q;
    hz.flush_cnt  = flush_cnt_q;
  end

  // Next-state: E stage takes a bubble on flush, M/W simply follow, counters saturate.
  always_comb begin
    rs1_e_d     = flush_e ? '0 : hz.Rs1_D;
    rs2_e_d     = flush_e ? '0 : hz.Rs2_D;
    rd_e_d      = flush_e ? '0 : hz.Rd_D;
    rd_m_d      = rd_e_q;
    rd_w_d      = rd_m_q;
    stall_cnt_d = sat_inc(stall_cnt_q, lw_stall);
    flush_cnt_d = sat_inc(flush_cnt_q, hz.PCSrcE);
  end

  // D->E, E->M, M->W address pipeline and event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_e_q     <= '0;
      rs2_e_q     <= '0;
      rd_e_q      <= '0;
      rd_m_q      <= '0;
      rd_w_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      rs1_e_q     <= rs1_e_d;
      rs2_e_q     <= rs2_e_d;
      rd_e_q      <= rd_e_d;
      rd_m_q      <= rd_m_d;
      rd_w_q      <= rd_w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: directed vector table, multi-cycle sequences and a
// randomized run against a behavioural model built from the pipeline rules.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_unit_if #(.REG_W(5), .CNT_W(16)) hif ();
  hazard_unit_if #(.REG_W(5), .CNT_W(4))  hif4 ();

  hazard_unit #(.REG_W(5), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .hz(hif.slave));
  hazard_unit #(.REG_W(5), .CNT_W(4))  dut4 (.clk(clk), .reset(reset), .hz(hif4.slave));

  // The narrow-counter instance sees exactly the same pipeline traffic.
  assign hif4.Rs1_D        = hif.Rs1_D;
  assign hif4.Rs2_D        = hif.Rs2_D;
  assign hif4.Rd_D         = hif.Rd_D;
  assign hif4.RegWrite_M   = hif.RegWrite_M;
  assign hif4.RegWrite_W   = hif.RegWrite_W;
  assign hif4.ResultSrc_E0 = hif.ResultSrc_E0;
  assign hif4.PCSrcE       = hif.PCSrcE;

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       rwm, rww, ld, pc;
    int         fa, fb;
    logic       st, fd, fe;
    int         sc, fc;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: E-stage sources, a destination history [E, M, W], counters.
  int m_rs1e, m_rs2e;
  int m_rd[$];
  int m_s16, m_f16, m_s4, m_f4;
  bit m_known;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit rst, input int rs1, input int rs2, input int rd,
                              input bit rwm, input bit rww, input bit ld, input bit pc,
                              input int fa, input int fb, input bit st, input bit fd,
                              input bit fe, input int sc, input int fc);
    vec_t v;
    v.rst = rst; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
    v.rwm = rwm; v.rww = rww; v.ld = ld; v.pc = pc;
    v.fa = fa; v.fb = fb; v.st = st; v.fd = fd; v.fe = fe; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.rst = ($urandom_range(0, 63) == 0);
    v.rs1 = 5'($urandom_range(0, 3));
    v.rs2 = 5'($urandom_range(0, 3));
    v.rd  = 5'($urandom_range(0, 3));
    v.rwm = 1'($urandom_range(0, 1));
    v.rww = 1'($urandom_range(0, 1));
    v.ld  = ($urandom_range(0, 2) == 0);
    v.pc  = ($urandom_range(0, 5) == 0);
    return v;
  endfunction

  function automatic int fwd_model(input int rs, input bit wm, input bit ww);
    if (rs == 0) return 0;
    if (wm && rs == m_rd[1]) return 2;
    if (ww && rs == m_rd[2]) return 1;
    return 0;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // One clock: drive, check at the falling edge, advance the model, move past the rising edge.
  task automatic cycle(input vec_t v, input bit use_tab);
    int efa, efb;
    bit lwraw, est, efe;
    reset            = v.rst;
    hif.Rs1_D        = v.rs1;
    hif.Rs2_D        = v.rs2;
    hif.Rd_D         = v.rd;
    hif.RegWrite_M   = v.rwm;
    hif.RegWrite_W   = v.rww;
    hif.ResultSrc_E0 = v.ld;
    hif.PCSrcE       = v.pc;
    @(negedge clk);
    efa   = v.rst ? 0 : fwd_model(int'(v.rs1) == 0 ? 0 : m_rs1e, v.rwm, v.rww);
    efa   = v.rst ? 0 : fwd_model(m_rs1e, v.rwm, v.rww);
    efb   = v.rst ? 0 : fwd_model(m_rs2e, v.rwm, v.rww);
    lwraw = v.ld && (m_rd[0] != 0) && ((int'(v.rs1) == m_rd[0]) || (int'(v.rs2) == m_rd[0]));
    est   = lwraw && !v.pc && !v.rst;
    efe   = est || v.pc;
    chk("ForwardA_E", 32'(hif.ForwardA_E), 32'(efa));
    chk("ForwardB_E", 32'(hif.ForwardB_E), 32'(efb));
    chk("StallF", 32'(hif.StallF), 32'(est));
    chk("StallD", 32'(hif.StallD), 32'(est));
    chk("FlushD", 32'(hif.FlushD), 32'(v.pc));
    chk("FlushE", 32'(hif.FlushE), 32'(efe));
    if (m_known) begin
      chk("stall_cnt", 32'(hif.stall_cnt), 32'(m_s16));
      chk("flush_cnt", 32'(hif.flush_cnt), 32'(m_f16));
      chk("stall_cnt4", 32'(hif4.stall_cnt), 32'(m_s4));
      chk("flush_cnt4", 32'(hif4.flush_cnt), 32'(m_f4));
    end
    if (use_tab) begin
      chk("tab_ForwardA_E", 32'(hif.ForwardA_E), 32'(v.fa));
      chk("tab_ForwardB_E", 32'(hif.ForwardB_E), 32'(v.fb));
      chk("tab_Stall", 32'(hif.StallF), 32'(v.st));
      chk("tab_FlushD", 32'(hif.FlushD), 32'(v.fd));
      chk("tab_FlushE", 32'(hif.FlushE), 32'(v.fe));
      chk("tab_stall_cnt", 32'(hif.stall_cnt), 32'(v.sc));
      chk("tab_flush_cnt", 32'(hif.flush_cnt), 32'(v.fc));
    end
    if (v.rst) begin
      m_rs1e = 0; m_rs2e = 0;
      m_rd = '{0, 0, 0};
      m_s16 = 0; m_f16 = 0; m_s4 = 0; m_f4 = 0;
      m_known = 1'b1;
    end else begin
      m_s16 = sat(m_s16 + int'(est), 65535);
      m_f16 = sat(m_f16 + int'(v.pc), 65535);
      m_s4  = sat(m_s4 + int'(est), 15);
      m_f4  = sat(m_f4 + int'(v.pc), 15);
      void'(m_rd.pop_back());
      m_rd.push_front(efe ? 0 : int'(v.rd));
      m_rs1e = efe ? 0 : int'(v.rs1);
      m_rs2e = efe ? 0 : int'(v.rs2);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[$];
    vec_t v;
    m_rs1e = 0; m_rs2e = 0; m_rd = '{0, 0, 0};
    m_s16 = 0; m_f16 = 0; m_s4 = 0; m_f4 = 0; m_known = 1'b0;
    hif.Rs1_D = '0; hif.Rs2_D = '0; hif.Rd_D = '0;
    hif.RegWrite_M = 1'b0; hif.RegWrite_W = 1'b0;
    hif.ResultSrc_E0 = 1'b0; hif.PCSrcE = 1'b0;
    @(posedge clk);
    #1;

    // Reset for two cycles under random traffic.
    for (int i = 0; i < 2; i++) begin
      v = rand_vec();
      v.rst = 1'b1;
      cycle(v, 1'b0);
    end
    chk("rd_e_after_reset", 32'(dut.rd_e_q), 32'd0);
    chk("rd_m_after_reset", 32'(dut.rd_m_q), 32'd0);
    chk("rd_w_after_reset", 32'(dut.rd_w_q), 32'd0);
    chk("stall_cnt_after_reset", 32'(hif.stall_cnt), 32'd0);
    chk("flush_cnt_after_reset", 32'(hif.flush_cnt), 32'd0);

    //           rst rs1 rs2 rd rwm rww ld pc  fa fb st fd fe sc fc
    // Forward from M: producer rd=5, consumer rs1=5, M writes.
    tab.push_back(mk(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    // M and W both hold rd=5: M wins on both operands.
    tab.push_back(mk(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 2, 2, 0, 0, 0, 0, 0));
    // x0 chain: addresses all zero with writes enabled never forward.
    tab.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Load-use on rs2: one stall, bubble, then forward from W.
    tab.push_back(mk(0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(0, 0, 7, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0));
    tab.push_back(mk(0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    // Taken branch with a load-use hazard present: flush wins, no stall.
    tab.push_back(mk(0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk(0, 9, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    // Reset with a stall pending drops it and clears Rd_E.
    tab.push_back(mk(0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tab.push_back(mk(1, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    tab.push_back(mk(0, 7, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (tab[i]) cycle(tab[i], 1'b1);

    // Flush counter saturation on the 4-bit instance.
    for (int i = 0; i < 20; i++) begin
      cycle(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    end
    chk("flush_cnt4_saturated", 32'(hif4.flush_cnt), 32'd15);
    chk("flush_cnt16_after_20", 32'(hif.flush_cnt), 32'd20);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(rand_vec(), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
